uart_rx_decoder: RTL and testbench

//  8N1 asynchronous serial receiver; the testbench-side decoder of the SoC UART TX line.

---
 rtl/uart_rx_decoder_if.sv | 28 ++
 rtl/uart_rx_decoder.sv | 148 ++++++++++++++
 tb/tb_uart_rx_decoder.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_decoder_if
// Description : Serial line and received-byte signals for the 8N1 receiver.
//               The master drives the line; the slave is the receiver.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_decoder_if;
    logic       i_Rx_Serial;
    logic       o_Rx_DV;
    logic [7:0] o_Rx_Byte;
    logic       o_Frame_Err;

    modport master (
        output i_Rx_Serial,
        input  o_Rx_DV,
        input  o_Rx_Byte,
        input  o_Frame_Err
    );

    modport slave (
        input  i_Rx_Serial,
        output o_Rx_DV,
        output o_Rx_Byte,
        output o_Frame_Err
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_decoder.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_decoder
// Description : 8N1 asynchronous serial receiver, oversampled by the system
//               clock; one-cycle valid or frame-error strobe per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_decoder #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    uart_rx_decoder_if.slave rx
);

    localparam int               c_CW   = $clog2(CLKS_PER_BIT);
    localparam logic [c_CW-1:0]  c_HALF = c_CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [c_CW-1:0]  c_LAST = c_CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_STOP    = 3'd3,
        S_CLEANUP = 3'd4
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_sync;
    logic            w_rx_s;
    logic [c_CW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]      r_idx, w_idx_nxt;
    logic [7:0]      r_shreg, w_shreg_nxt;
    logic [7:0]      r_byte, w_byte_nxt;
    logic            r_dv, w_dv_nxt;
    logic            r_err, w_err_nxt;
    logic            r_need_high, w_need_high_nxt;

    assign w_rx_s = r_sync[1];

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_sync      <= 2'b11;
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= 3'd0;
            r_shreg     <= 8'h00;
            r_byte      <= 8'h00;
            r_dv        <= 1'b0;
            r_err       <= 1'b0;
            r_need_high <= 1'b0;
        end else begin
            r_sync      <= {r_sync[0], rx.i_Rx_Serial};
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_shreg     <= w_shreg_nxt;
            r_byte      <= w_byte_nxt;
            r_dv        <= w_dv_nxt;
            r_err       <= w_err_nxt;
            r_need_high <= w_need_high_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_idx_nxt       = r_idx;
        w_shreg_nxt     = r_shreg;
        w_byte_nxt      = r_byte;
        w_dv_nxt        = 1'b0;
        w_err_nxt       = 1'b0;
        w_need_high_nxt = r_need_high;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                // After a low stop bit the line must go idle before a new start counts
                if (r_need_high) begin
                    if (w_rx_s) begin
                        w_need_high_nxt = 1'b0;
                    end
                end else if (!w_rx_s) begin
                    w_state_nxt = S_START;
                end
            end

            S_START: begin
                if (r_cnt == c_HALF) begin
                    w_cnt_nxt = '0;
                    if (!w_rx_s) begin
                        w_state_nxt = S_DATA;
                        w_idx_nxt   = 3'd0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            S_DATA: begin
                if (r_cnt == c_LAST) begin
                    w_cnt_nxt          = '0;
                    w_shreg_nxt[r_idx] = w_rx_s;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            S_STOP: begin
                if (r_cnt == c_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_CLEANUP;
                    if (w_rx_s) begin
                        w_byte_nxt = r_shreg;
                        w_dv_nxt   = 1'b1;
                    end else begin
                        w_err_nxt       = 1'b1;
                        w_need_high_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            S_CLEANUP: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign rx.o_Rx_DV     = r_dv;
    assign rx.o_Rx_Byte   = r_byte;
    assign rx.o_Frame_Err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_decoder
// Description : Self-checking bench for uart_rx_decoder (16 and 868 clk/bit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_decoder;

    localparam int c_CPB_F = 16;
    localparam int c_CPB_S = 868;
    localparam int c_LAT_F = (c_CPB_F - 1) / 2 + 9 * c_CPB_F + 4;
    localparam int c_LAT_S = (c_CPB_S - 1) / 2 + 9 * c_CPB_S + 4;

    logic clk;
    logic rst;
    int   cyc;
    int   n_assert;
    int   n_fail;

    uart_rx_decoder_if bus_f ();
    uart_rx_decoder_if bus_s ();

    uart_rx_decoder #(.CLKS_PER_BIT(c_CPB_F)) dut_f (
        .i_Clock (clk),
        .i_Reset (rst),
        .rx      (bus_f)
    );

    uart_rx_decoder #(.CLKS_PER_BIT(c_CPB_S)) dut_s (
        .i_Clock (clk),
        .i_Reset (rst),
        .rx      (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed events from both receivers
    logic [7:0] got_f[$];
    logic [7:0] got_s[$];
    int         dvcyc_f[$];
    int         dvcyc_s[$];
    int         err_f;
    int         err_s;
    int         viol;
    logic       prev_dv_f, prev_err_f, prev_dv_s, prev_err_s;

    // Reference model state
    logic [7:0] exp_f[$];
    logic [7:0] exp_s[$];
    int         fall_f[$];
    int         fall_s[$];
    logic [7:0] last_f;
    logic [7:0] last_s;
    int         exp_err_f;

    initial begin
        err_f = 0; err_s = 0; viol = 0;
        prev_dv_f = 1'b0; prev_err_f = 1'b0; prev_dv_s = 1'b0; prev_err_s = 1'b0;
    end

    always @(negedge clk) begin
        if (bus_f.o_Rx_DV) begin
            got_f.push_back(bus_f.o_Rx_Byte);
            dvcyc_f.push_back(cyc);
        end
        if (bus_f.o_Frame_Err) err_f++;
        if (bus_s.o_Rx_DV) begin
            got_s.push_back(bus_s.o_Rx_Byte);
            dvcyc_s.push_back(cyc);
        end
        if (bus_s.o_Frame_Err) err_s++;
        if ((bus_f.o_Rx_DV && bus_f.o_Frame_Err) || (bus_f.o_Rx_DV && prev_dv_f) ||
            (bus_f.o_Frame_Err && prev_err_f)) viol++;
        if ((bus_s.o_Rx_DV && bus_s.o_Frame_Err) || (bus_s.o_Rx_DV && prev_dv_s) ||
            (bus_s.o_Frame_Err && prev_err_s)) viol++;
        prev_dv_f  = bus_f.o_Rx_DV;
        prev_err_f = bus_f.o_Frame_Err;
        prev_dv_s  = bus_s.o_Rx_DV;
        prev_err_s = bus_s.o_Frame_Err;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Line always changes 1 time unit after a rising edge
    task automatic drive_f(input logic v, input int n);
        bus_f.i_Rx_Serial = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_s(input logic v, input int n);
        bus_s.i_Rx_Serial = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_f(input logic [7:0] b, input logic stop);
        if (stop) begin
            exp_f.push_back(b);
            fall_f.push_back(cyc);
            last_f = b;
        end else begin
            exp_err_f++;
        end
        drive_f(1'b0, c_CPB_F);
        for (int i = 0; i < 8; i++) drive_f(b[i], c_CPB_F);
        drive_f(stop, c_CPB_F);
    endtask

    task automatic send_s(input logic [7:0] b);
        exp_s.push_back(b);
        fall_s.push_back(cyc);
        last_s = b;
        drive_s(1'b0, c_CPB_S);
        for (int i = 0; i < 8; i++) drive_s(b[i], c_CPB_S);
        drive_s(1'b1, c_CPB_S);
    endtask

    task automatic check_f(input string tag);
        int d;
        check({tag, "_count"}, 32'(got_f.size()), 32'(exp_f.size()));
        while (got_f.size() > 0 && exp_f.size() > 0)
            check({tag, "_byte"}, 32'(got_f.pop_front()), 32'(exp_f.pop_front()));
        while (dvcyc_f.size() > 0 && fall_f.size() > 0) begin
            d = dvcyc_f.pop_front() - fall_f.pop_front();
            check({tag, "_latency_ok"}, 32'(d >= c_LAT_F - 1 && d <= c_LAT_F + 1), 32'd1);
        end
        got_f.delete(); exp_f.delete(); dvcyc_f.delete(); fall_f.delete();
        check({tag, "_hold_byte"}, 32'(bus_f.o_Rx_Byte), 32'(last_f));
        check({tag, "_frame_errs"}, 32'(err_f), 32'(exp_err_f));
    endtask

    task automatic check_s(input string tag);
        int d;
        check({tag, "_count"}, 32'(got_s.size()), 32'(exp_s.size()));
        while (got_s.size() > 0 && exp_s.size() > 0)
            check({tag, "_byte"}, 32'(got_s.pop_front()), 32'(exp_s.pop_front()));
        while (dvcyc_s.size() > 0 && fall_s.size() > 0) begin
            d = dvcyc_s.pop_front() - fall_s.pop_front();
            check({tag, "_latency_ok"}, 32'(d >= c_LAT_S - 1 && d <= c_LAT_S + 1), 32'd1);
        end
        got_s.delete(); exp_s.delete(); dvcyc_s.delete(); fall_s.delete();
        check({tag, "_hold_byte"}, 32'(bus_s.o_Rx_Byte), 32'(last_s));
        check({tag, "_frame_errs"}, 32'(err_s), 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        n_assert = 0; n_fail = 0;
        last_f = 8'h00; last_s = 8'h00; exp_err_f = 0;
        bus_f.i_Rx_Serial = 1'b1;
        bus_s.i_Rx_Serial = 1'b1;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset_dv", 32'(bus_f.o_Rx_DV), 32'd0);
        check("reset_err", 32'(bus_f.o_Frame_Err), 32'd0);
        check("reset_byte", 32'(bus_f.o_Rx_Byte), 32'h00);
        drive_f(1'b1, 3 * c_CPB_F);

        send_f(8'h55, 1'b1);
        drive_f(1'b1, 2 * c_CPB_F);
        check_f("single_55");

        send_f(8'h00, 1'b1);
        send_f(8'hFF, 1'b1);
        drive_f(1'b1, 2 * c_CPB_F);
        check_f("b2b_00_ff");

        drive_f(1'b0, 5);
        drive_f(1'b1, 3 * c_CPB_F);
        check_f("glitch");

        send_f(8'hA5, 1'b1);
        drive_f(1'b1, c_CPB_F);
        check_f("after_glitch_a5");

        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            if (i == 7 && b == 8'hA5) b = 8'h5A;
            send_f(b, 1'b1);
        end
        drive_f(1'b1, 2 * c_CPB_F);
        check_f("random_b2b");

        send_f(8'hA5, 1'b0);
        drive_f(1'b0, 40 * c_CPB_F);
        drive_f(1'b1, 2 * c_CPB_F);
        check_f("frame_err_held_low");

        send_f(8'h3C, 1'b1);
        drive_f(1'b1, c_CPB_F);
        check_f("after_err_3c");

        // Abort 8'hC3 part-way through data bit 4 with a one-cycle reset
        b = 8'hC3;
        drive_f(1'b0, c_CPB_F);
        for (int i = 0; i < 4; i++) drive_f(b[i], c_CPB_F);
        drive_f(b[4], c_CPB_F / 2);
        rst = 1'b1;
        bus_f.i_Rx_Serial = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_f = 8'h00;
        check("midreset_dv", 32'(bus_f.o_Rx_DV), 32'd0);
        drive_f(1'b1, 2 * c_CPB_F);
        check_f("midreset_c3");

        send_f(8'h96, 1'b1);
        drive_f(1'b1, c_CPB_F);
        check_f("after_reset_96");

        drive_s(1'b1, 4);
        send_s(8'h41);
        send_s(8'h0A);
        drive_s(1'b1, 2 * c_CPB_S / 4);
        check_s("slow_41_0a");

        check("strobe_overlap_or_width", 32'(viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
